mul_div_unit: RTL and testbench

Multiply/divide unit for the pipelined CPU's EX stage. It is the responder side of the `start`/`busy` handshake that the stall logic drives. Each accepted MULT/MULTU/DIV/DIVU runs for a fixed number of cycles, holds `busy` high for that time, then writes the HI/LO registers. MTHI/MTLO write directly, and HI/LO are always readable combinationally for MFHI/MFLO.

---
 rtl/mul_div_unit.sv | 207 ++++++++++++++++++++
 tb/tb_mul_div_unit.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// mul_div_unit: HI/LO multiply/divide unit for the EX stage.
// Accepts MULT/MULTU/DIV/DIVU on start, holds busy for a fixed latency,
// then commits the precomputed result to HI/LO. MTHI/MTLO write from IDLE.
// Optional feature macro: MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU (codes 7-10).
//
// state | meaning
// IDLE  | no operation in flight; MTHI/MTLO accepted
// RUN   | counting down latency; result held in res_hi/res_lo
module mul_div_unit #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [3:0]  ctrl,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] CTRL_MULT  = 4'd1;
  localparam logic [3:0] CTRL_MULTU = 4'd2;
  localparam logic [3:0] CTRL_DIV   = 4'd3;
  localparam logic [3:0] CTRL_DIVU  = 4'd4;
  localparam logic [3:0] CTRL_MTHI  = 4'd5;
  localparam logic [3:0] CTRL_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] CTRL_MADD  = 4'd7;
  localparam logic [3:0] CTRL_MADDU = 4'd8;
  localparam logic [3:0] CTRL_MSUB  = 4'd9;
  localparam logic [3:0] CTRL_MSUBU = 4'd10;
`endif

  localparam logic [3:0] MUL_CNT = 4'(MUL_CYCLES);
  localparam logic [3:0] DIV_CNT = 4'(DIV_CYCLES);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        busy_nxt;
  logic [31:0] res_hi, res_hi_nxt;
  logic [31:0] res_lo, res_lo_nxt;
  logic        res_wr, res_wr_nxt;
  logic [31:0] hi_nxt, lo_nxt;

  // operation decode results
  logic        op_valid;
  logic        op_wr;
  logic [3:0]  op_cnt;
  logic [31:0] op_hi, op_lo;

  logic        last_cycle;
  assign last_cycle = (state == RUN) && (cnt == 4'd1);

  // products: low 64 bits of sign/zero-extended operands
  logic [63:0] prod_s, prod_u;
  assign prod_u = {32'b0, src_a} * {32'b0, src_b};
  assign prod_s = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};

  // divide on magnitudes; 0x80000000 / -1 falls out naturally as 0x80000000 r 0
  logic        div_signed, a_neg, b_neg;
  logic [31:0] mag_a, mag_b, div_b, q_mag, r_mag, quot, rem;
  assign div_signed = (ctrl == CTRL_DIV);
  assign a_neg      = div_signed & src_a[31];
  assign b_neg      = div_signed & src_b[31];
  assign mag_a      = a_neg ? -src_a : src_a;
  assign mag_b      = b_neg ? -src_b : src_b;
  assign div_b      = (mag_b == 32'd0) ? 32'd1 : mag_b;
  assign q_mag      = mag_a / div_b;
  assign r_mag      = mag_a % div_b;
  assign quot       = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem        = a_neg ? -r_mag : r_mag;

`ifdef MDU_MADD_EN
  // accumulate base forwards a result committing at this same edge
  logic [63:0] acc_base;
  assign acc_base = (last_cycle && res_wr) ? {res_hi, res_lo} : {hi, lo};
`endif

  // decode ctrl into the result and latency of an accepted operation
  always_comb begin
    op_valid = 1'b0;
    op_wr    = 1'b0;
    op_cnt   = MUL_CNT;
    op_hi    = 32'd0;
    op_lo    = 32'd0;
    case (ctrl)
      CTRL_MULT: begin
        op_valid       = 1'b1;
        op_wr          = 1'b1;
        {op_hi, op_lo} = prod_s;
      end
      CTRL_MULTU: begin
        op_valid       = 1'b1;
        op_wr          = 1'b1;
        {op_hi, op_lo} = prod_u;
      end
      CTRL_DIV, CTRL_DIVU: begin
        op_valid = 1'b1;
        op_wr    = (src_b != 32'd0);
        op_cnt   = DIV_CNT;
        op_hi    = rem;
        op_lo    = quot;
      end
`ifdef MDU_MADD_EN
      CTRL_MADD: begin
        op_valid       = 1'b1;
        op_wr          = 1'b1;
        {op_hi, op_lo} = acc_base + prod_s;
      end
      CTRL_MADDU: begin
        op_valid       = 1'b1;
        op_wr          = 1'b1;
        {op_hi, op_lo} = acc_base + prod_u;
      end
      CTRL_MSUB: begin
        op_valid       = 1'b1;
        op_wr          = 1'b1;
        {op_hi, op_lo} = acc_base - prod_s;
      end
      CTRL_MSUBU: begin
        op_valid       = 1'b1;
        op_wr          = 1'b1;
        {op_hi, op_lo} = acc_base - prod_u;
      end
`endif
      default: ;
    endcase
  end

  // next-state, counter, shadow and HI/LO update
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    busy_nxt   = busy;
    res_hi_nxt = res_hi;
    res_lo_nxt = res_lo;
    res_wr_nxt = res_wr;
    hi_nxt     = hi;
    lo_nxt     = lo;
    case (state)
      IDLE: begin
        if (start && op_valid) begin
          state_nxt  = RUN;
          cnt_nxt    = op_cnt;
          busy_nxt   = 1'b1;
          res_hi_nxt = op_hi;
          res_lo_nxt = op_lo;
          res_wr_nxt = op_wr;
        end else if (ctrl == CTRL_MTHI) begin
          hi_nxt = src_a;
        end else if (ctrl == CTRL_MTLO) begin
          lo_nxt = src_a;
        end
      end
      RUN: begin
        if (cnt == 4'd1) begin
          if (res_wr) begin
            hi_nxt = res_hi;
            lo_nxt = res_lo;
          end
          if (start && op_valid) begin
            cnt_nxt    = op_cnt;
            res_hi_nxt = op_hi;
            res_lo_nxt = op_lo;
            res_wr_nxt = op_wr;
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = 4'd0;
            busy_nxt  = 1'b0;
          end
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // state register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      busy   <= 1'b0;
      res_hi <= 32'd0;
      res_lo <= 32'd0;
      res_wr <= 1'b0;
      hi     <= 32'd0;
      lo     <= 32'd0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      busy   <= busy_nxt;
      res_hi <= res_hi_nxt;
      res_lo <= res_lo_nxt;
      res_wr <= res_wr_nxt;
      hi     <= hi_nxt;
      lo     <= lo_nxt;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: vector table plus hand-written
// sequences for back-to-back issue, MTLO during RUN, mid-op reset and MADDU.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  ctrl = 4'd0;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        busy;
  logic [31:0] hi, lo;

  int tests = 0;
  int failed = 0;

  mul_div_unit dut (
    .clk(clk), .reset_n(reset_n), .start(start), .ctrl(ctrl),
    .src_a(src_a), .src_b(src_b), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    int          cyc;
    logic [31:0] eh;
    logic [31:0] el;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp);
    end
  endtask

  // issue one op at a negedge, count busy cycles, check HI/LO held then final
  task automatic run_vec(input vec_t v, input int idx);
    logic [31:0] old_hi, old_lo;
    int n;
    logic held;
    @(negedge clk);
    start = v.st; ctrl = v.ctrl; src_a = v.a; src_b = v.b;
    old_hi = hi; old_lo = lo;
    @(negedge clk);
    start = 1'b0; ctrl = 4'd0; src_a = 32'd0; src_b = 32'd0;
    n = 0; held = 1'b1;
    while (busy && n < 40) begin
      if (hi !== old_hi || lo !== old_lo) held = 1'b0;
      n++;
      @(negedge clk);
    end
    chk("busy_cycles", idx, 32'(n), 32'(v.cyc));
    chk("held_during_busy", idx, {31'd0, held}, 32'd1);
    chk("hi", idx, hi, v.eh);
    chk("lo", idx, lo, v.el);
  endtask

  initial begin
    int n;
    logic flag;
    vec_t v;

    vecs[0]  = '{1'b1, 4'd1, 32'hFFFFFFFE, 32'd3,         5,  32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1]  = '{1'b1, 4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF,  5,  32'hFFFFFFFE, 32'h00000001};
    vecs[2]  = '{1'b1, 4'd3, 32'hFFFFFFF9, 32'd2,         10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{1'b1, 4'd4, 32'd7,        32'd0,         10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4]  = '{1'b1, 4'd3, 32'h80000000, 32'hFFFFFFFF,  10, 32'h00000000, 32'h80000000};
    vecs[5]  = '{1'b1, 4'd4, 32'd100,      32'd7,         10, 32'd2,        32'd14};
    vecs[6]  = '{1'b1, 4'd3, 32'd7,        32'hFFFFFFFE,  10, 32'd1,        32'hFFFFFFFD};
    vecs[7]  = '{1'b1, 4'd1, 32'h80000000, 32'h80000000,  5,  32'h40000000, 32'h00000000};
    vecs[8]  = '{1'b1, 4'd11, 32'd5,       32'd6,         0,  32'h40000000, 32'h00000000};
    vecs[9]  = '{1'b0, 4'd5, 32'h12345678, 32'd0,         0,  32'h12345678, 32'h00000000};
    vecs[10] = '{1'b1, 4'd6, 32'hCAFEF00D, 32'd0,         0,  32'h12345678, 32'hCAFEF00D};
    vecs[11] = '{1'b1, 4'd4, 32'hFFFFFFFF, 32'h10,        10, 32'h0000000F, 32'h0FFFFFFF};

    repeat (3) @(negedge clk);
    chk("reset_busy", 0, {31'd0, busy}, 32'd0);
    chk("reset_hi", 0, hi, 32'd0);
    chk("reset_lo", 0, lo, 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // MTLO while RUN is ignored
    @(negedge clk);
    start = 1'b1; ctrl = 4'd1; src_a = 32'd2; src_b = 32'd3;
    @(negedge clk);
    start = 1'b0; ctrl = 4'd6; src_a = 32'hDEADBEEF;
    @(negedge clk);
    ctrl = 4'd0; src_a = 32'd0; src_b = 32'd0;
    n = 0;
    while (busy && n < 40) begin n++; @(negedge clk); end
    chk("mtlo_in_run_cycles", 0, 32'(n), 32'd4);
    chk("mtlo_in_run_hi", 0, hi, 32'd0);
    chk("mtlo_in_run_lo", 0, lo, 32'd6);

    // back-to-back: second op accepted at the edge where the first commits
    @(negedge clk);
    start = 1'b1; ctrl = 4'd2; src_a = 32'd3; src_b = 32'd4;
    @(negedge clk);
    start = 1'b0; ctrl = 4'd0;
    repeat (4) @(negedge clk);
    start = 1'b1; ctrl = 4'd2; src_a = 32'd5; src_b = 32'd6;
    @(negedge clk);
    start = 1'b0; ctrl = 4'd0; src_a = 32'd0; src_b = 32'd0;
    chk("b2b_busy", 0, {31'd0, busy}, 32'd1);
    chk("b2b_first_lo", 0, lo, 32'd12);
    n = 0;
    while (busy && n < 40) begin n++; @(negedge clk); end
    chk("b2b_second_cycles", 0, 32'(n), 32'd5);
    chk("b2b_second_lo", 0, lo, 32'd30);
    chk("b2b_second_hi", 0, hi, 32'd0);

    // reset on cycle 3 of a DIV discards it
    @(negedge clk);
    start = 1'b1; ctrl = 4'd3; src_a = 32'd100; src_b = 32'd3;
    @(negedge clk);
    start = 1'b0; ctrl = 4'd0; src_a = 32'd0; src_b = 32'd0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", 0, {31'd0, busy}, 32'd0);
    chk("rst_mid_hi", 0, hi, 32'd0);
    chk("rst_mid_lo", 0, lo, 32'd0);
    reset_n = 1'b1;
    flag = 1'b1;
    repeat (15) begin
      @(negedge clk);
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) flag = 1'b0;
    end
    chk("rst_no_late_commit", 0, {31'd0, flag}, 32'd1);

    // MADDU 1x1 on {hi,lo} = {0, 0xFFFFFFFF}
    v = '{1'b0, 4'd5, 32'd0, 32'd0, 0, 32'd0, 32'd0};
    run_vec(v, 100);
    v = '{1'b0, 4'd6, 32'hFFFFFFFF, 32'd0, 0, 32'd0, 32'hFFFFFFFF};
    run_vec(v, 101);
`ifdef MDU_MADD_EN
    v = '{1'b1, 4'd8, 32'd1, 32'd1, 5, 32'd1, 32'd0};
`else
    v = '{1'b1, 4'd8, 32'd1, 32'd1, 0, 32'd0, 32'hFFFFFFFF};
`endif
    run_vec(v, 102);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

endmodule
